// File: rtl/object_renderer.sv
// Two-stage sprite renderer: four rectangles (two balls, two rackets) over a live background,
// with per-frame shadowed object state and ball/racket collision flags.
module object_renderer #(
  parameter int BALL_W = 16,
  parameter int BALL_H = 16,
  parameter int RACK_W = 16,
  parameter int RACK_H = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start_strobe,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  input  logic        pix_de,
  input  logic        pix_hs,
  input  logic        pix_vs,
  input  logic [47:0] obj_x,
  input  logic [47:0] obj_y,
  input  logic [3:0]  obj_en,
  input  logic [95:0] obj_color,
  input  logic [23:0] bg_color,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic [3:0]  hit_flags
);

  logic [3:0]  w_cov;
  logic [23:0] w_scol [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_obj
      localparam int OBJ_W = (gi < 2) ? BALL_W : RACK_W;
      localparam int OBJ_H = (gi < 2) ? BALL_H : RACK_H;
      localparam logic [12:0] W_M1 = 13'(OBJ_W - 1);
      localparam logic [12:0] H_M1 = 13'(OBJ_H - 1);

      logic [11:0] r_sx;
      logic [11:0] r_sy;
      logic [23:0] r_col;
      logic        r_en;
      logic [12:0] w_x_end;
      logic [12:0] w_y_end;

      // Position and colour are don't-care until the enable is reloaded by a strobe.
      always_ff @(posedge clk) begin
        if (frame_start_strobe) begin
          r_sx  <= obj_x[gi*12 +: 12];
          r_sy  <= obj_y[gi*12 +: 12];
          r_col <= obj_color[gi*24 +: 24];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_en <= 1'b0;
        end else if (frame_start_strobe) begin
          r_en <= obj_en[gi];
        end
      end

      // 13-bit extents so an object near 4095 clips instead of wrapping to 0.
      assign w_x_end = {1'b0, r_sx} + W_M1;
      assign w_y_end = {1'b0, r_sy} + H_M1;

      assign w_cov[gi] = r_en
                         && (pix_x >= r_sx) && ({1'b0, pix_x} <= w_x_end)
                         && (pix_y >= r_sy) && ({1'b0, pix_y} <= w_y_end);
      assign w_scol[gi] = r_col;
    end
  endgenerate

  logic [3:0]  r_cov1;
  logic        r_de1;
  logic        r_hs1;
  logic        r_vs1;
  logic [3:0]  r_acc;
  logic [23:0] w_pix_rgb;
  logic [3:0]  w_pairs;

  always_comb begin
    w_pix_rgb = r_de1 ? bg_color : 24'h000000;
    for (int k = 3; k >= 0; k--) begin
      if (r_cov1[k]) w_pix_rgb = w_scol[k];
    end
  end

  assign w_pairs = {r_cov1[1] & r_cov1[3], r_cov1[1] & r_cov1[2],
                    r_cov1[0] & r_cov1[3], r_cov1[0] & r_cov1[2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cov1    <= 4'd0;
      r_de1     <= 1'b0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      rgb_out   <= 24'h000000;
      de_out    <= 1'b0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      r_acc     <= 4'd0;
      hit_flags <= 4'd0;
    end else begin
      r_cov1  <= pix_de ? w_cov : 4'd0;
      r_de1   <= pix_de;
      r_hs1   <= pix_hs;
      r_vs1   <= pix_vs;
      rgb_out <= w_pix_rgb;
      de_out  <= r_de1;
      hs_out  <= r_hs1;
      vs_out  <= r_vs1;
      // Collisions seen in the strobe cycle itself belong to neither frame.
      if (frame_start_strobe) begin
        hit_flags <= r_acc;
        r_acc     <= 4'd0;
      end else begin
        r_acc <= r_acc | w_pairs;
      end
    end
  end

endmodule

// File: tb/tb_object_renderer.sv
// Bench for object_renderer: directed literal probes plus randomized traffic, all checked
// every cycle against a pixel-level model of the rendering rules.
module tb_object_renderer;

  localparam int BW = 16, BH = 16, RW = 16, RH = 64;
  localparam logic [23:0] BG = 24'h102030;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start_strobe;
  logic [11:0] pix_x, pix_y;
  logic        pix_de, pix_hs, pix_vs;
  logic [47:0] obj_x, obj_y;
  logic [3:0]  obj_en;
  logic [95:0] obj_color;
  logic [23:0] bg_color;
  logic [23:0] rgb_out;
  logic        de_out, hs_out, vs_out;
  logic [3:0]  hit_flags;

  int n_tests = 0;
  int n_fail  = 0;

  object_renderer #(.BALL_W(BW), .BALL_H(BH), .RACK_W(RW), .RACK_H(RH)) dut (
    .clk(clk), .reset(reset), .frame_start_strobe(frame_start_strobe),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en), .obj_color(obj_color),
    .bg_color(bg_color), .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out),
    .vs_out(vs_out), .hit_flags(hit_flags)
  );

  always #5 clk = ~clk;

  // Model: frame-latched object table, one in-flight pixel record, expected outputs.
  int          m_sx [4];
  int          m_sy [4];
  logic [23:0] m_col [4];
  logic [3:0]  m_en;
  logic [3:0]  m_p1_cov;
  logic        m_p1_de, m_p1_hs, m_p1_vs;
  logic [3:0]  m_acc, m_hit;
  logic [23:0] e_rgb;
  logic        e_de, e_hs, e_vs;

  function automatic bit covers(int k, int x, int y);
    int w, h;
    w = (k < 2) ? BW : RW;
    h = (k < 2) ? BH : RH;
    return m_en[k] && x >= m_sx[k] && x <= m_sx[k] + w - 1 && y >= m_sy[k] && y <= m_sy[k] + h - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [3:0] cov;
    if (reset) begin
      m_en = '0; m_acc = '0; m_hit = '0;
      m_p1_cov = '0; m_p1_de = 0; m_p1_hs = 0; m_p1_vs = 0;
      e_rgb = '0; e_de = 0; e_hs = 0; e_vs = 0;
    end else begin
      e_rgb = m_p1_de ? bg_color : 24'h0;
      for (int k = 0; k < 4; k++) begin
        if (m_p1_cov[k]) begin
          e_rgb = m_col[k];
          break;
        end
      end
      e_de = m_p1_de; e_hs = m_p1_hs; e_vs = m_p1_vs;
      if (frame_start_strobe) begin
        m_hit = m_acc;
        m_acc = '0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_p1_cov[b / 2] && m_p1_cov[2 + b % 2]) m_acc[b] = 1'b1;
      end
      cov = '0;
      for (int k = 0; k < 4; k++) cov[k] = pix_de && covers(k, pix_x, pix_y);
      m_p1_cov = cov; m_p1_de = pix_de; m_p1_hs = pix_hs; m_p1_vs = pix_vs;
      if (frame_start_strobe) begin
        for (int k = 0; k < 4; k++) begin
          m_sx[k]  = int'(obj_x[k*12 +: 12]);
          m_sy[k]  = int'(obj_y[k*12 +: 12]);
          m_col[k] = obj_color[k*24 +: 24];
          m_en[k]  = obj_en[k];
        end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("rgb", rgb_out, e_rgb);
    chk("sync", {de_out, hs_out, vs_out}, {e_de, e_hs, e_vs});
    chk("hit", hit_flags, m_hit);
  endtask

  task automatic set_obj(input int k, input int x, input int y, input logic [23:0] c);
    obj_x[k*12 +: 12]     = 12'(x);
    obj_y[k*12 +: 12]     = 12'(y);
    obj_color[k*24 +: 24] = c;
  endtask

  task automatic strobe();
    frame_start_strobe = 1'b1;
    pix_de = 1'b0;
    step();
    frame_start_strobe = 1'b0;
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [23:0] exp);
    pix_x = 12'(x); pix_y = 12'(y); pix_de = 1'b1;
    step();
    pix_de = 1'b0;
    step();
    chk(name, rgb_out, exp);
    $display("[TB] probe %s (%0d,%0d) rgb=%06h", name, x, y, rgb_out);
  endtask

  function automatic logic [11:0] rc();
    return ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 100)) : 12'($urandom_range(4030, 4095));
  endfunction

  initial begin
    reset = 1; frame_start_strobe = 0;
    pix_x = 0; pix_y = 0; pix_de = 0; pix_hs = 0; pix_vs = 0;
    obj_x = '0; obj_y = '0; obj_en = '0; obj_color = '0; bg_color = BG;
    for (int k = 0; k < 4; k++) begin m_sx[k] = 0; m_sy[k] = 0; m_col[k] = '0; end
    repeat (3) step();
    chk("reset_rgb", rgb_out, 24'h0);
    chk("reset_de", de_out, 1'b0);
    chk("reset_hit", hit_flags, 4'h0);
    reset = 0;

    // Latency: pixel and syncs emerge exactly two cycles later.
    strobe();
    pix_de = 1; pix_hs = 1; pix_vs = 1;
    step();
    chk("lat_1cyc", {de_out, hs_out, vs_out}, 3'b000);
    pix_de = 0; pix_hs = 0; pix_vs = 0;
    step();
    chk("lat_2cyc", {de_out, hs_out, vs_out}, 3'b111);
    chk("lat_bg", rgb_out, BG);
    step();
    chk("lat_after", {de_out, hs_out, vs_out}, 3'b000);

    // Edge coverage.
    set_obj(0, 100, 200, 24'hAABBCC); obj_en = 4'b0001;
    strobe();
    probe("edge_tl", 100, 200, 24'hAABBCC);
    probe("edge_br", 115, 215, 24'hAABBCC);
    probe("edge_l", 99, 200, BG);
    probe("edge_r", 116, 200, BG);
    probe("edge_b", 100, 216, BG);

    // Priority.
    set_obj(0, 50, 50, 24'hFF0000); set_obj(2, 50, 50, 24'h0000FF); obj_en = 4'b0101;
    strobe();
    probe("prio_red", 55, 55, 24'hFF0000);
    probe("prio_blue", 55, 100, 24'h0000FF);
    probe("prio_bg", 70, 55, BG);

    // Shadowing.
    set_obj(0, 100, 200, 24'h00FF00); obj_en = 4'b0001;
    strobe();
    obj_x[11:0] = 12'd300;
    probe("shadow_old", 100, 200, 24'h00FF00);
    strobe();
    probe("shadow_gone", 100, 200, BG);
    probe("shadow_new", 300, 200, 24'h00FF00);

    // Clipping at the right edge.
    set_obj(0, 4090, 0, 24'h123456);
    strobe();
    probe("clip_in", 4095, 15, 24'h123456);
    probe("clip_wrap", 0, 0, BG);

    // Collisions.
    set_obj(1, 10, 10, 24'h00FFFF); set_obj(3, 12, 12, 24'hFF00FF); obj_en = 4'b1010;
    strobe();
    probe("coll_px", 12, 12, 24'h00FFFF);
    set_obj(1, 500, 500, 24'h00FFFF);
    strobe();
    chk("hit_n1", hit_flags, 4'b1000);
    $display("[TB] strobe hit_flags=%b", hit_flags);
    probe("coll_none", 12, 12, 24'hFF00FF);
    strobe();
    chk("hit_n2", hit_flags, 4'b0000);
    $display("[TB] strobe hit_flags=%b", hit_flags);

    // Reset mid-frame with an overlap in flight.
    set_obj(1, 10, 10, 24'h00FFFF);
    strobe();
    pix_x = 12; pix_y = 12; pix_de = 1;
    repeat (3) step();
    reset = 1;
    step();
    chk("rst_hit", hit_flags, 4'h0);
    chk("rst_rgb", rgb_out, 24'h0);
    reset = 0; pix_de = 0;
    probe("rst_bg0", 12, 12, BG);
    obj_en = 4'b0000;
    strobe();
    chk("rst_hit_strobe", hit_flags, 4'h0);
    probe("rst_bg1", 12, 12, BG);
    obj_en = 4'b1010;
    strobe();
    probe("rst_obj", 12, 12, 24'h00FFFF);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      frame_start_strobe = ($urandom_range(0, 39) == 0);
      pix_x = rc(); pix_y = rc();
      pix_de = 1'($urandom); pix_hs = 1'($urandom); pix_vs = 1'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 4; k++) set_obj(k, int'(rc()), int'(rc()), 24'($urandom));
        obj_en = 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) bg_color = 24'($urandom);
      step();
    end
    reset = 0; frame_start_strobe = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
